sram_128x22_ctrl: RTL and testbench

//  Initiator-side controller for the 128x22 single-port synchronous SRAM macro wrapper.

---
 rtl/sram_128x22_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_sram_128x22_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_128x22_ctrl.sv
// sram_128x22_ctrl
//   Initiator-side controller for a 128x22 single-port synchronous SRAM.
//   Accepts read/write requests on a valid/ready port. Drives the SRAM
//   address, write-enable and data pins. Collects read data in a 2-entry,
//   in-order response FIFO. After reset it can sweep every word to zero
//   before it accepts any traffic.
//
// Parameters
//   AW              address width (matches the SRAM)
//   DW              data width (matches the SRAM)
//   DEPTH           number of SRAM words covered by the clear sweep
//   CLEAR_ON_RESET  1: zero every word after reset, 0: skip the sweep
//
// Ports
//   clk        in   clock, rising edge; also clocks the SRAM
//   rst        in   asynchronous active-high reset
//   req_valid  in   request valid
//   req_ready  out  request ready
//   req_we     in   1 = write, 0 = read
//   req_addr   in   request word address
//   req_wdata  in   write data
//   rsp_valid  out  read response valid (registered)
//   rsp_ready  in   read response ready
//   rsp_data   out  read data at the head of the response FIFO (registered)
//   init_done  out  high once the controller is running
//   mem_addr   out  SRAM ADDR
//   mem_wen    out  SRAM WEN, active-low
//   mem_din    out  SRAM DATA_IN
//   mem_dout   in   SRAM DATA_OUT, valid in the cycle after the read edge
module sram_128x22_ctrl #(
  parameter int AW             = 7,
  parameter int DW             = 22,
  parameter int DEPTH          = 128,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          init_done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wen,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state_reg, state_next;
  logic [AW-1:0] clr_cnt_reg;
  logic          clr_last;

  // Response path: head register drives the outputs directly. The skid
  // entry holds the second response while the head is stalled.
  logic          infl_reg;
  logic          rsp_valid_reg;
  logic [DW-1:0] rsp_data_reg;
  logic          skid_valid_reg;
  logic [DW-1:0] skid_data_reg;

  logic [1:0]    outstanding;
  logic          credit_ok;
  logic          pop;
  logic          push;
  logic          read_accept;

  assign clr_last = (clr_cnt_reg == LAST_ADDR);

  // Every accepted read owns a FIFO slot from acceptance onwards. A slot
  // freed by a pop this cycle can be reused by the request this cycle.
  assign outstanding = {1'b0, rsp_valid_reg} + {1'b0, skid_valid_reg} + {1'b0, infl_reg};
  assign pop         = rsp_valid_reg & rsp_ready;
  assign credit_ok   = (outstanding < 2'd2) | pop;
  assign read_accept = req_valid & req_ready & ~req_we;
  // SRAM data for a read accepted on the previous edge is on mem_dout now.
  assign push        = infl_reg;

  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign init_done = (state_reg == ST_RUN);

  always_comb begin
    state_next = state_reg;
    mem_wen    = 1'b1;
    mem_addr   = '0;
    mem_din    = '0;
    req_ready  = 1'b0;
    case (state_reg)
      ST_WAIT: begin
        state_next = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      end
      ST_INIT: begin
        mem_wen  = 1'b0;
        mem_addr = clr_cnt_reg;
        if (clr_last) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        mem_addr  = req_addr;
        mem_din   = req_wdata;
        req_ready = credit_ok;
        mem_wen   = ~(req_valid & credit_ok & req_we);
      end
      default: begin
        state_next = ST_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_WAIT;
      clr_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Saturates on the last word so the count never wraps.
      if (state_reg == ST_INIT && !clr_last) begin
        clr_cnt_reg <= clr_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_reg       <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_data_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
    end else begin
      infl_reg <= read_accept;
      case ({push, pop})
        2'b11: begin
          // Occupancy unchanged: the queue shifts by one and the new data
          // goes to the tail.
          if (skid_valid_reg) begin
            rsp_data_reg  <= skid_data_reg;
            skid_data_reg <= mem_dout;
          end else begin
            rsp_data_reg <= mem_dout;
          end
        end
        2'b10: begin
          if (rsp_valid_reg) begin
            skid_data_reg  <= mem_dout;
            skid_valid_reg <= 1'b1;
          end else begin
            rsp_data_reg  <= mem_dout;
            rsp_valid_reg <= 1'b1;
          end
        end
        2'b01: begin
          if (skid_valid_reg) begin
            rsp_data_reg   <= skid_data_reg;
            skid_valid_reg <= 1'b0;
          end else begin
            rsp_valid_reg <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The credit scheme should make a push into a full FIFO unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && skid_valid_reg));

endmodule

// File: tb/tb_sram_128x22_ctrl.sv
module tb_sram_128x22_ctrl;

  localparam int AW    = 7;
  localparam int DW    = 22;
  localparam int DEPTH = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_ready = 1'b0;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          init_done;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  // Second instance without the clear sweep; only its start-up is observed.
  logic          nc_req_valid = 1'b0;
  logic          nc_req_we = 1'b0;
  logic [AW-1:0] nc_req_addr = '0;
  logic [DW-1:0] nc_req_wdata = '0;
  logic          nc_rsp_ready = 1'b0;
  logic [DW-1:0] nc_mem_dout = '0;
  logic          nc_req_ready;
  logic          nc_rsp_valid;
  logic [DW-1:0] nc_rsp_data;
  logic          nc_init_done;
  logic [AW-1:0] nc_mem_addr;
  logic          nc_mem_wen;
  logic [DW-1:0] nc_mem_din;

  sram_128x22_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .init_done(init_done),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  sram_128x22_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .CLEAR_ON_RESET(0)) dut_nc (
    .clk(clk), .rst(rst),
    .req_valid(nc_req_valid), .req_ready(nc_req_ready), .req_we(nc_req_we),
    .req_addr(nc_req_addr), .req_wdata(nc_req_wdata),
    .rsp_valid(nc_rsp_valid), .rsp_ready(nc_rsp_ready), .rsp_data(nc_rsp_data),
    .init_done(nc_init_done),
    .mem_addr(nc_mem_addr), .mem_wen(nc_mem_wen), .mem_din(nc_mem_din), .mem_dout(nc_mem_dout)
  );

  // Behavioural single-port synchronous SRAM.
  logic [DW-1:0] sram [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) sram[i] = '0;
    mem_dout = '0;
  end
  always @(posedge clk) begin
    if (!mem_wen) sram[mem_addr] <= mem_din;
    else          mem_dout <= sram[mem_addr];
  end

  // Reference model: memory contents plus a queue of outstanding reads,
  // each tagged with the edge count from which it is visible.
  typedef struct {
    logic [DW-1:0] data;
    int            vis;
  } rsp_t;

  logic [DW-1:0] model_mem [DEPTH];
  rsp_t          exp_q [$];
  int            cyc = 0;
  bit            model_run = 1'b0;
  int            n_pops = 0;

  int n_checks = 0;
  int n_errs   = 0;

  logic          s_rsp_valid;
  logic [DW-1:0] s_rsp_data;
  logic          s_req_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One RUN cycle: entered at a negedge, leaves at the next negedge.
  task automatic step(input logic v, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic rr, output logic acc);
    logic head_valid;
    logic pop;
    logic exp_ready;
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; rsp_ready = rr;
    #3;
    head_valid = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
    pop        = head_valid && rr;
    exp_ready  = model_run && ((exp_q.size() < 2) || pop);
    acc        = v && exp_ready;
    s_rsp_valid = rsp_valid; s_rsp_data = rsp_data; s_req_ready = req_ready;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(head_valid));
    if (head_valid) chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
    chk("mem_wen", 32'(mem_wen), 32'(!(acc && we)));
    chk("mem_addr", 32'(mem_addr), 32'(a));
    chk("mem_din", 32'(mem_din), 32'(d));
    @(posedge clk);
    cyc++;
    if (pop) begin
      $display("txn rsp data=%06h", exp_q[0].data);
      void'(exp_q.pop_front());
      n_pops++;
    end
    if (acc && !we) begin
      exp_q.push_back('{model_mem[a], cyc + 1});
      $display("txn rd  addr=%02h", a);
    end
    if (acc && we) begin
      model_mem[a] = d;
      $display("txn wr  addr=%02h data=%06h", a, d);
    end
    @(negedge clk);
  endtask

  // Entered at a negedge with rst high; releases reset and checks the sweep.
  task automatic init_seq();
    model_run = 1'b0;
    exp_q.delete();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 7'h5A; req_wdata = 22'h155555; rsp_ready = 1'b1;
    #2;
    chk("rst_flags", 32'({req_ready, rsp_valid, init_done, mem_wen, nc_init_done}), 32'(5'b00010));
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_din", 32'(mem_din), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("wait_state", 32'({mem_wen, req_ready, init_done, nc_init_done}), 32'(4'b1000));
    for (int k = 1; k <= DEPTH; k++) begin
      @(negedge clk);
      #3;
      chk("sweep", {mem_wen, mem_addr, mem_din, req_ready, init_done},
          {1'b0, AW'(k - 1), DW'(0), 1'b0, 1'b0});
      if (k == 1) chk("nc_init_done", 32'(nc_init_done), 1);
    end
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    #3;
    chk("init_done", 32'({init_done, req_ready, rsp_valid}), 32'(3'b110));
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_run = 1'b1;
  endtask

  typedef struct {
    logic          v;
    logic          we;
    logic [DW-1:0] wdata;
    logic          exp_rv;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t t6 [11];

  initial begin
    logic acc;
    int   idx;
    int   p0;
    logic rv, rwe, rrr;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;

    // Alternating write/read at address 0, one request per cycle.
    t6[0]  = '{1'b1, 1'b1, 22'h3FFFFF, 1'b0, 22'h0};
    t6[1]  = '{1'b1, 1'b0, 22'h0,      1'b0, 22'h0};
    t6[2]  = '{1'b1, 1'b1, 22'h000001, 1'b0, 22'h0};
    t6[3]  = '{1'b1, 1'b0, 22'h0,      1'b1, 22'h3FFFFF};
    t6[4]  = '{1'b1, 1'b1, 22'h3FFFFF, 1'b0, 22'h0};
    t6[5]  = '{1'b1, 1'b0, 22'h0,      1'b1, 22'h000001};
    t6[6]  = '{1'b1, 1'b1, 22'h000001, 1'b0, 22'h0};
    t6[7]  = '{1'b1, 1'b0, 22'h0,      1'b1, 22'h3FFFFF};
    t6[8]  = '{1'b0, 1'b0, 22'h0,      1'b0, 22'h0};
    t6[9]  = '{1'b0, 1'b0, 22'h0,      1'b1, 22'h000001};
    t6[10] = '{1'b0, 1'b0, 22'h0,      1'b0, 22'h0};

    @(negedge clk);
    init_seq();

    // Cleared memory reads back zero.
    step(1, 0, 7'h55, 0, 1, acc);
    step(0, 0, 0, 0, 1, acc);
    step(0, 0, 0, 0, 1, acc);

    // Write then read the same address on the next cycle.
    step(1, 1, 7'h7F, 22'h2AAAAA, 1, acc);
    step(1, 0, 7'h7F, 0, 1, acc);
    step(0, 0, 0, 0, 1, acc);
    chk("t2_not_early", 32'(s_rsp_valid), 0);
    step(0, 0, 0, 0, 1, acc);
    chk("t2_valid", 32'(s_rsp_valid), 1);
    chk("t2_data", 32'(s_rsp_data), 32'h2AAAAA);

    // Back-to-back reads at full throughput.
    for (int i = 0; i < 16; i++) step(1, 1, AW'(i), DW'(i), 1, acc);
    p0 = n_pops;
    for (int i = 0; i < 16; i++) begin
      step(1, 0, AW'(i), 0, 1, acc);
      chk("t3_ready", 32'(s_req_ready), 1);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, acc);
    chk("t3_responses", n_pops - p0, 16);

    // Backpressure: two reads fit, the third waits for the first pop.
    step(1, 1, 7'h10, 22'h000111, 1, acc);
    step(1, 1, 7'h11, 22'h000222, 1, acc);
    step(1, 1, 7'h12, 22'h000333, 1, acc);
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      step(1, 0, AW'(7'h10 + idx), 0, 0, acc);
      if (acc) idx++;
    end
    chk("t4_accepted_stalled", idx, 2);
    chk("t4_ready_low", 32'(s_req_ready), 0);
    chk("t4_data_held", 32'(s_rsp_data), 32'h000111);
    step(1, 0, AW'(7'h10 + idx), 0, 1, acc);
    chk("t4_third_on_pop", 32'({s_req_ready, s_rsp_valid}), 32'(2'b11));
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, acc);

    // Table-driven write/read alternation.
    for (int i = 0; i < 11; i++) begin
      step(t6[i].v, t6[i].we, 7'h00, t6[i].wdata, 1, acc);
      chk("t6_rsp_valid", 32'(s_rsp_valid), 32'(t6[i].exp_rv));
      if (t6[i].exp_rv) chk("t6_rsp_data", 32'(s_rsp_data), 32'(t6[i].exp_rd));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rv    = ($urandom_range(0, 3) != 0);
      rwe   = ($urandom_range(0, 1) != 0);
      raddr = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      rdata = DW'($urandom);
      rrr   = ($urandom_range(0, 3) != 0);
      step(rv, rwe, raddr, rdata, rrr, acc);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, acc);

    // Reset in the middle of the clear sweep.
    rst = 1'b1;
    model_run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 41; k++) @(negedge clk);
    #2;
    chk("t5_sweep_at_40", 32'(mem_addr), 40);
    #1 rst = 1'b1;
    #1;
    chk("t5_async_rst_init", 32'({mem_wen, mem_addr, init_done, req_ready}), 32'({1'b1, 7'h00, 1'b0, 1'b0}));
    @(negedge clk);
    init_seq();

    // Reset in RUN with two responses pending.
    step(1, 1, 7'h20, 22'h0ABCDE, 1, acc);
    step(1, 0, 7'h20, 0, 0, acc);
    step(1, 0, 7'h7F, 0, 0, acc);
    step(0, 0, 0, 0, 0, acc);
    step(0, 0, 0, 0, 0, acc);
    chk("t5_pending", 32'({s_rsp_valid, s_req_ready}), 32'(2'b10));
    #2 rst = 1'b1;
    #1;
    chk("t5_async_rst_run", 32'({rsp_valid, req_ready, init_done, mem_wen}), 32'(4'b0001));
    chk("t5_rsp_data_clr", 32'(rsp_data), 0);
    @(negedge clk);
    init_seq();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, acc);
    step(1, 0, 7'h20, 0, 1, acc);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, acc);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
